// File: rtl/osd_vram_wr_sched.sv
// OSD character VRAM write scheduler: merges a small CPU write FIFO with a fill/clear
// engine and issues at most one VRAM write per cycle, only while the video window is open.
module osd_vram_wr_sched #(
    parameter int C_AW        = 10,
    parameter int C_DW        = 8,
    parameter int C_FIFO_LG   = 2,
    parameter int C_FILL_LAST = 1023
) (
    input  logic            CK_i,
    input  logic            SYS_R_i,
    input  logic            CPU_WE_i,
    input  logic [C_AW-1:0] CPU_WAs_i,
    input  logic [C_DW-1:0] CPU_WDs_i,
    input  logic            FILL_REQ_i,
    input  logic [C_DW-1:0] FILL_DATAs_i,
    input  logic            WIN_i,
    input  logic            CLR_DROP_i,
    output logic            VRAM_WE_o,
    output logic [C_AW-1:0] VRAM_WAs_o,
    output logic [C_DW-1:0] VRAM_WDs_o,
    output logic            FIFO_FULL_o,
    output logic            DROP_o,
    output logic            BUSY_o,
    output logic            FILL_DONE_o
);
    localparam int                C_DEPTH     = 1 << C_FIFO_LG;
    localparam int                C_EW        = C_AW + C_DW;
    localparam logic [C_AW-1:0]   C_LAST_ADDR = C_AW'(C_FILL_LAST);
    localparam logic [C_FIFO_LG:0] C_DEPTH_CNT = (C_FIFO_LG + 1)'(C_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Edge detectors
    logic cpu_we_prev_q;
    logic fill_req_prev_q;
    logic cpu_edge;
    logic fill_edge;

    // CPU write FIFO
    logic [C_EW-1:0]      mem_q [C_DEPTH];
    logic [C_FIFO_LG-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_FIFO_LG-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_FIFO_LG:0]   cnt_q, cnt_d;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push_ok;
    logic                 drop_evt;
    logic                 pop;
    logic [C_EW-1:0]      head;

    // Fill engine
    state_t          state_q, state_d;
    logic [C_AW-1:0] fill_addr_q, fill_addr_d;
    logic [C_DW-1:0] fill_data_q, fill_data_d;

    // Issue path
    logic            issue_cpu;
    logic            issue_fill;
    logic            issue_we;
    logic [C_AW-1:0] issue_wa;
    logic [C_DW-1:0] issue_wd;
    logic [C_AW-1:0] last_wa_q, last_wa_d;
    logic [C_DW-1:0] last_wd_q, last_wd_d;
    logic            drop_q, drop_d;

    assign cpu_edge  = CPU_WE_i & ~cpu_we_prev_q;
    assign fill_edge = FILL_REQ_i & ~fill_req_prev_q;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == C_DEPTH_CNT);
    assign head       = mem_q[rd_ptr_q];

    // Issue handshake: VRAM_WE_o is a valid with no backpressure; WIN_i acts as ready,
    // and a source advances (FIFO pop or fill addr++) only in a cycle where both are high.
    assign issue_cpu  = WIN_i & ~fifo_empty;
    assign issue_fill = WIN_i & fifo_empty & (state_q == ST_FILL);
    assign issue_we   = issue_cpu | issue_fill;
    assign issue_wa   = issue_cpu ? head[C_EW-1:C_DW] : fill_addr_q;
    assign issue_wd   = issue_cpu ? head[C_DW-1:0]    : fill_data_q;

    assign pop      = issue_cpu;
    assign push_ok  = cpu_edge & (~fifo_full | pop);
    assign drop_evt = cpu_edge & fifo_full & ~pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_FIFO_LG'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + C_FIFO_LG'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (C_FIFO_LG + 1)'(1);
            2'b01:   cnt_d = cnt_q - (C_FIFO_LG + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Clear wins over a same-cycle overflow.
    always_comb begin
        drop_d = drop_q;
        if (CLR_DROP_i) begin
            drop_d = 1'b0;
        end else if (drop_evt) begin
            drop_d = 1'b1;
        end
    end

    always_comb begin
        last_wa_d = last_wa_q;
        last_wd_d = last_wd_q;
        if (issue_we) begin
            last_wa_d = issue_wa;
            last_wd_d = issue_wd;
        end
    end

    // Fill FSM: the address stops at the last one instead of wrapping.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_edge) begin
                    state_d     = ST_FILL;
                    fill_addr_d = '0;
                    fill_data_d = FILL_DATAs_i;
                end
            end
            ST_FILL: begin
                if (issue_fill) begin
                    if (fill_addr_q == C_LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        fill_addr_d = fill_addr_q + C_AW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK_i or posedge SYS_R_i) begin
        if (SYS_R_i) begin
            cpu_we_prev_q   <= 1'b0;
            fill_req_prev_q <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            cnt_q           <= '0;
            drop_q          <= 1'b0;
            state_q         <= ST_IDLE;
            fill_addr_q     <= '0;
            fill_data_q     <= '0;
            last_wa_q       <= '0;
            last_wd_q       <= '0;
        end else begin
            cpu_we_prev_q   <= CPU_WE_i;
            fill_req_prev_q <= FILL_REQ_i;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            cnt_q           <= cnt_d;
            drop_q          <= drop_d;
            state_q         <= state_d;
            fill_addr_q     <= fill_addr_d;
            fill_data_q     <= fill_data_d;
            last_wa_q       <= last_wa_d;
            last_wd_q       <= last_wd_d;
        end
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge CK_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {CPU_WAs_i, CPU_WDs_i};
        end
    end

    assign VRAM_WE_o   = issue_we;
    assign VRAM_WAs_o  = issue_we ? issue_wa : last_wa_q;
    assign VRAM_WDs_o  = issue_we ? issue_wd : last_wd_q;
    assign FIFO_FULL_o = fifo_full;
    assign DROP_o      = drop_q;
    assign BUSY_o      = (state_q == ST_FILL);
    assign FILL_DONE_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_osd_vram_wr_sched.sv
// Bench for osd_vram_wr_sched: cycle vectors for the CPU FIFO path, hand sequences for
// the fill engine (basic, CPU interleave, window pause, reset mid-fill, held-through-reset).
module tb_osd_vram_wr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_we = 1'b0;
  logic [9:0] cpu_wa = '0;
  logic [7:0] cpu_wd = '0;
  logic       fill_req = 1'b0;
  logic [7:0] fill_data = '0;
  logic       win = 1'b0;
  logic       clr_drop = 1'b0;
  logic       vram_we;
  logic [9:0] vram_wa;
  logic [7:0] vram_wd;
  logic       fifo_full;
  logic       drop;
  logic       busy;
  logic       fill_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_q[$];
  logic [7:0]  vram [1024];

  osd_vram_wr_sched #(
    .C_AW(10), .C_DW(8), .C_FIFO_LG(2), .C_FILL_LAST(15)
  ) dut (
    .CK_i(clk), .SYS_R_i(rst),
    .CPU_WE_i(cpu_we), .CPU_WAs_i(cpu_wa), .CPU_WDs_i(cpu_wd),
    .FILL_REQ_i(fill_req), .FILL_DATAs_i(fill_data),
    .WIN_i(win), .CLR_DROP_i(clr_drop),
    .VRAM_WE_o(vram_we), .VRAM_WAs_o(vram_wa), .VRAM_WDs_o(vram_wd),
    .FIFO_FULL_o(fifo_full), .DROP_o(drop), .BUSY_o(busy), .FILL_DONE_o(fill_done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       c;
    logic [9:0] a;
    logic [7:0] d;
    logic       w;
    logic       cl;
    logic       e_we;
    logic [9:0] e_wa;
    logic [7:0] e_wd;
    logic       e_full;
    logic       e_drop;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;

  task automatic add_v(input logic c, input logic [9:0] a, input logic [7:0] d,
                       input logic w, input logic cl, input logic e_we,
                       input logic [9:0] e_wa, input logic [7:0] e_wd,
                       input logic e_full, input logic e_drop);
    vecs[nv] = '{c, a, d, w, cl, e_we, e_wa, e_wd, e_full, e_drop};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // driver: inputs change just after the falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  // scoreboard monitor, sampled 1ns after inputs settle and well before the rising edge
  task automatic mon();
    logic [17:0] e;
    #1;
    if (vram_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %0h/%0h, required no write", vram_wa, vram_wd);
      end else begin
        e = exp_q.pop_front();
        if ({vram_wa, vram_wd} !== e) begin
          n_fail++;
          $display("FAIL write_order: got %0h/%0h, required %0h/%0h",
                   vram_wa, vram_wd, e[17:8], e[7:0]);
        end
      end
      vram[vram_wa] = vram_wd;
    end
  endtask

  task automatic fill_basic(input logic [7:0] pat);
    for (int a = 0; a < 16; a++) exp_q.push_back({10'(a), pat});
    cyc(); fill_req = 1'b1; fill_data = pat; win = 1'b1; mon();
    chk("fill_busy_pre", busy, 1'b0);
    cyc(); mon();
    chk("fill_busy", busy, 1'b1);
    repeat (15) begin cyc(); mon(); end
    cyc(); mon();
    chk("fill_done_pulse", fill_done, 1'b1);
    chk("fill_busy_fall", busy, 1'b0);
    cyc(); fill_req = 1'b0; mon();
    chk("fill_done_once", fill_done, 1'b0);
    chk("fill_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = '0;

    // CPU FIFO vectors: inputs for the cycle, then outputs expected in that cycle
    add_v(0,10'h000,8'h00,1,0, 0,10'h000,8'h00,0,0);
    add_v(1,10'h123,8'h41,1,0, 0,10'h000,8'h00,0,0);
    add_v(1,10'h123,8'h41,1,0, 1,10'h123,8'h41,0,0);
    add_v(1,10'h123,8'h41,1,0, 0,10'h123,8'h41,0,0);
    add_v(0,10'h000,8'h00,1,0, 0,10'h123,8'h41,0,0);
    add_v(1,10'h001,8'h11,0,0, 0,10'h123,8'h41,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h123,8'h41,0,0);
    add_v(1,10'h002,8'h12,0,0, 0,10'h123,8'h41,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h123,8'h41,0,0);
    add_v(1,10'h003,8'h13,0,0, 0,10'h123,8'h41,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h123,8'h41,0,0);
    add_v(1,10'h004,8'h14,0,0, 0,10'h123,8'h41,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h123,8'h41,1,0);
    add_v(1,10'h005,8'h15,0,0, 0,10'h123,8'h41,1,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h123,8'h41,1,1);
    add_v(0,10'h000,8'h00,1,0, 1,10'h001,8'h11,1,1);
    add_v(0,10'h000,8'h00,1,0, 1,10'h002,8'h12,0,1);
    add_v(0,10'h000,8'h00,1,0, 1,10'h003,8'h13,0,1);
    add_v(0,10'h000,8'h00,1,0, 1,10'h004,8'h14,0,1);
    add_v(0,10'h000,8'h00,1,0, 0,10'h004,8'h14,0,1);
    add_v(0,10'h000,8'h00,0,1, 0,10'h004,8'h14,0,1);
    add_v(0,10'h000,8'h00,0,0, 0,10'h004,8'h14,0,0);
    add_v(1,10'h010,8'h50,0,0, 0,10'h004,8'h14,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h004,8'h14,0,0);
    add_v(1,10'h011,8'h51,0,0, 0,10'h004,8'h14,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h004,8'h14,0,0);
    add_v(1,10'h012,8'h52,0,0, 0,10'h004,8'h14,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h004,8'h14,0,0);
    add_v(1,10'h013,8'h53,0,0, 0,10'h004,8'h14,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h004,8'h14,1,0);
    add_v(1,10'h014,8'h54,1,0, 1,10'h010,8'h50,1,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h011,8'h51,1,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h012,8'h52,0,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h013,8'h53,0,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h014,8'h54,0,0);
    add_v(0,10'h000,8'h00,1,0, 0,10'h014,8'h54,0,0);
    add_v(1,10'h020,8'h60,0,0, 0,10'h014,8'h54,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h014,8'h54,0,0);
    add_v(1,10'h021,8'h61,0,0, 0,10'h014,8'h54,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h014,8'h54,0,0);
    add_v(1,10'h022,8'h62,0,0, 0,10'h014,8'h54,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h014,8'h54,0,0);
    add_v(1,10'h023,8'h63,0,0, 0,10'h014,8'h54,0,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h014,8'h54,1,0);
    add_v(1,10'h024,8'h64,0,1, 0,10'h014,8'h54,1,0);
    add_v(0,10'h000,8'h00,0,0, 0,10'h014,8'h54,1,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h020,8'h60,1,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h021,8'h61,0,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h022,8'h62,0,0);
    add_v(0,10'h000,8'h00,1,0, 1,10'h023,8'h63,0,0);
    add_v(0,10'h000,8'h00,1,0, 0,10'h023,8'h63,0,0);

    // reset block
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", vram_we, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", fill_done, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      cyc();
      cpu_we = vecs[i].c; cpu_wa = vecs[i].a; cpu_wd = vecs[i].d;
      win = vecs[i].w; clr_drop = vecs[i].cl;
      #1;
      chk($sformatf("vec%0d_we", i), vram_we, vecs[i].e_we);
      chk($sformatf("vec%0d_wa", i), vram_wa, vecs[i].e_wa);
      chk($sformatf("vec%0d_wd", i), vram_wd, vecs[i].e_wd);
      chk($sformatf("vec%0d_full", i), fifo_full, vecs[i].e_full);
      chk($sformatf("vec%0d_drop", i), drop, vecs[i].e_drop);
    end
    cyc(); cpu_we = 1'b0; clr_drop = 1'b0; win = 1'b1; mon();

    // plain fill of 0..15
    fill_basic(8'h20);

    // CPU write to an already-filled address lands between fill addr 2 and 3
    for (int a = 0; a < 3; a++) exp_q.push_back({10'(a), 8'h33});
    exp_q.push_back({10'h001, 8'h77});
    for (int a = 3; a < 16; a++) exp_q.push_back({10'(a), 8'h33});
    cyc(); fill_req = 1'b1; fill_data = 8'h33; mon();
    cyc(); fill_req = 1'b0; mon();
    cyc(); mon();
    cyc(); cpu_we = 1'b1; cpu_wa = 10'h001; cpu_wd = 8'h77; mon();
    cyc(); cpu_we = 1'b0; mon();
    repeat (13) begin cyc(); mon(); end
    cyc(); mon();
    chk("ilv_done", fill_done, 1'b1);
    chk("ilv_q_empty", exp_q.size(), 0);
    chk("ilv_cpu_persists", vram[1], 8'h77);
    chk("ilv_fill_addr5", vram[5], 8'h33);

    // window closes for 10 cycles before fill addr 7
    for (int a = 0; a < 16; a++) exp_q.push_back({10'(a), 8'h44});
    cyc(); fill_req = 1'b1; fill_data = 8'h44; mon();
    cyc(); fill_req = 1'b0; mon();
    repeat (6) begin cyc(); mon(); end
    for (int k = 0; k < 10; k++) begin
      cyc(); win = 1'b0; mon();
      chk($sformatf("pause%0d_we", k), vram_we, 1'b0);
    end
    chk("pause_busy", busy, 1'b1);
    cyc(); win = 1'b1; mon();
    chk("pause_resume_addr", vram_wa, 10'h007);
    repeat (8) begin cyc(); mon(); end
    cyc(); mon();
    chk("pause_done", fill_done, 1'b1);
    chk("pause_q_empty", exp_q.size(), 0);

    // reset mid-fill with two queued CPU entries
    for (int a = 0; a < 3; a++) exp_q.push_back({10'(a), 8'h66});
    cyc(); fill_req = 1'b1; fill_data = 8'h66; mon();
    cyc(); fill_req = 1'b0; mon();
    cyc(); mon();
    cyc(); mon();
    cyc(); win = 1'b0; cpu_we = 1'b1; cpu_wa = 10'h2AA; cpu_wd = 8'hA1; mon();
    cyc(); cpu_we = 1'b0; mon();
    cyc(); cpu_we = 1'b1; cpu_wa = 10'h2BB; cpu_wd = 8'hB2; mon();
    cyc(); cpu_we = 1'b0; mon();
    chk("mid_q_empty", exp_q.size(), 0);
    cyc(); rst = 1'b1; win = 1'b1; #1;
    chk("mid_rst_we", vram_we, 1'b0);
    chk("mid_rst_wa", vram_wa, 10'h000);
    chk("mid_rst_wd", vram_wd, 8'h00);
    chk("mid_rst_full", fifo_full, 1'b0);
    chk("mid_rst_drop", drop, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", fill_done, 1'b0);
    cyc();
    cyc(); rst = 1'b0; mon();
    for (int k = 0; k < 3; k++) begin
      cyc(); mon();
      chk($sformatf("post_rst%0d_we", k), vram_we, 1'b0);
    end
    fill_basic(8'h55);
    chk("old_entry_2aa", vram[10'h2AA], 8'h00);
    chk("old_entry_2bb", vram[10'h2BB], 8'h00);

    // CPU_WE held high through reset counts as one edge
    cyc(); rst = 1'b1; cpu_we = 1'b1; cpu_wa = 10'h3FF; cpu_wd = 8'hEE; #1;
    chk("held_rst_we", vram_we, 1'b0);
    cyc();
    cyc(); rst = 1'b0; exp_q.push_back({10'h3FF, 8'hEE}); mon();
    cyc(); mon();
    chk("held_q_empty", exp_q.size(), 0);
    cyc(); mon();
    cyc(); cpu_we = 1'b0; mon();
    chk("held_no_repeat", vram_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
